// File: rtl/countdown_ctrl.sv
// Countdown control stage: 1 s tick prescaler, start/pause/clear handling,
// digit preset strobes and DONE alarm. Optional macro AUTO_RELOAD_EN makes it a repeating timer.
module countdown_ctrl #(
   parameter int TICK_DIV   = 100000000,
   parameter int DONE_TICKS = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start_btn,
   input  logic pause_btn,
   input  logic clear_btn,
   input  logic digits_zero,
   output logic ce_out,
   output logic load,
   output logic running,
   output logic paused,
   output logic done,
   output logic alarm
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DONE_TICKS + 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic            start_q, pause_q, clear_q;
   logic            ce_q, ce_d;
   logic            load_q, load_d;
   logic            running_q, running_d;
   logic            paused_q, paused_d;
   logic            done_q, done_d;
   logic            alarm_q, alarm_d;

   logic            start_rise, pause_rise, clear_rise;
   logic            tick, zero_det;
   logic [PW-1:0]   presc_adv;

   always_comb begin
      start_rise = start_btn & ~start_q;
      pause_rise = pause_btn & ~pause_q;
      clear_rise = clear_btn & ~clear_q;
      tick       = (presc_q == PW'(TICK_DIV - 1));
      presc_adv  = tick ? '0 : presc_q + PW'(1);
      // digits_zero is stale while a preset or a count enable is landing
      zero_det   = digits_zero & ~load_q & ~ce_q;

      state_d = state_q;
      presc_d = presc_q;
      dcnt_d  = dcnt_q;
      alarm_d = alarm_q;
      load_d  = 1'b0;
      ce_d    = 1'b0;

      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (clear_rise) begin
               load_d = 1'b1;
            end else if (start_rise) begin
               state_d = RUN;
               load_d  = 1'b1;
            end
         end
         RUN: begin
            presc_d = presc_adv;
            if (clear_rise) begin
               state_d = IDLE;
               load_d  = 1'b1;
               presc_d = '0;
            end else if (pause_rise) begin
               state_d = PAUSE;
            end else if (zero_det) begin
               state_d = DONE;
               dcnt_d  = '0;
               alarm_d = 1'b0;
            end else if (tick) begin
               ce_d = 1'b1;
            end
         end
         PAUSE: begin
            if (clear_rise) begin
               state_d = IDLE;
               load_d  = 1'b1;
               presc_d = '0;
            end else if (pause_rise || start_rise) begin
               state_d = RUN;
            end
         end
         DONE: begin
            presc_d = presc_adv;
            if (start_rise || pause_rise || clear_rise) begin
               state_d = IDLE;
               presc_d = '0;
               dcnt_d  = '0;
               alarm_d = 1'b0;
            end else if (tick) begin
               if (dcnt_q == DW'(DONE_TICKS - 1)) begin
                  dcnt_d  = '0;
                  alarm_d = 1'b0;
                  presc_d = '0;
`ifdef AUTO_RELOAD_EN
                  state_d = RUN;
                  load_d  = 1'b1;
`else
                  state_d = IDLE;
`endif
               end else begin
                  dcnt_d  = dcnt_q + DW'(1);
                  alarm_d = ~alarm_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      running_d = (state_d == RUN);
      paused_d  = (state_d == PAUSE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         dcnt_q    <= '0;
         start_q   <= 1'b1;
         pause_q   <= 1'b1;
         clear_q   <= 1'b1;
         ce_q      <= 1'b0;
         load_q    <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         dcnt_q    <= dcnt_d;
         start_q   <= start_btn;
         pause_q   <= pause_btn;
         clear_q   <= clear_btn;
         ce_q      <= ce_d;
         load_q    <= load_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
         alarm_q   <= alarm_d;
      end
   end

   assign ce_out  = ce_q;
   assign load    = load_q;
   assign running = running_q;
   assign paused  = paused_q;
   assign done    = done_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random button
// and zero-flag traffic, all checked every cycle against a rule-level model.
module tb_countdown_ctrl;
   localparam int TD = 4;
   localparam int DT = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0;
   logic reset, start_btn, pause_btn, clear_btn, digits_zero;
   logic ce_out, load, running, paused, done, alarm;

   countdown_ctrl #(.TICK_DIV(TD), .DONE_TICKS(DT)) dut (
      .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
      .clear_btn(clear_btn), .digits_zero(digits_zero), .ce_out(ce_out),
      .load(load), .running(running), .paused(paused), .done(done), .alarm(alarm)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: mode, RUN/DONE cycles since last tick, ticks spent in DONE
   int   m_mode, m_phase, m_dt;
   logic m_alarm, m_load, m_ce;
   logic pv_s, pv_p, pv_c;
   logic [5:0] obs, exp_v;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_phase = 0; m_dt = 0;
      m_alarm = 0; m_load = 0; m_ce = 0;
      pv_s = 1; pv_p = 1; pv_c = 1;
   endtask

   task automatic model_step(input logic s, input logic p, input logic c, input logic z);
      logic rs, rp, rc, tk, nload, nce;
      int nm;
      rs = s & ~pv_s; rp = p & ~pv_p; rc = c & ~pv_c;
      pv_s = s; pv_p = p; pv_c = c;
      tk = (m_mode == M_RUN || m_mode == M_DONE) && (m_phase == TD - 1);
      nm = m_mode; nload = 0; nce = 0;
      if (m_mode == M_IDLE) begin
         if (rc) nload = 1;
         else if (rs) begin nm = M_RUN; nload = 1; end
      end else if (m_mode == M_RUN) begin
         if (rc) begin nm = M_IDLE; nload = 1; end
         else if (rp) nm = M_PAUSE;
         else if (z && !m_load && !m_ce) nm = M_DONE;
         else if (tk) nce = 1;
      end else if (m_mode == M_PAUSE) begin
         if (rc) begin nm = M_IDLE; nload = 1; end
         else if (rp || rs) nm = M_RUN;
      end else begin
         if (rs || rp || rc) nm = M_IDLE;
         else if (tk) begin
            m_alarm = ~m_alarm;
            m_dt++;
            if (m_dt == DT) begin
`ifdef AUTO_RELOAD_EN
               nm = M_RUN; nload = 1;
`else
               nm = M_IDLE;
`endif
            end
         end
      end
      if (m_mode == M_RUN || m_mode == M_DONE) m_phase = (m_phase + 1) % TD;
      if (nm == M_IDLE || (nm == M_RUN && m_mode != M_RUN && m_mode != M_PAUSE)) m_phase = 0;
      if (nm != M_DONE) begin m_alarm = 0; m_dt = 0; end
      m_mode = nm; m_load = nload; m_ce = nce;
   endtask

   // one clock: drive, advance model, sample after the edge and compare
   task automatic step(input logic s, input logic p, input logic c, input logic z);
      @(negedge clk);
      start_btn = s; pause_btn = p; clear_btn = c; digits_zero = z;
      model_step(s, p, c, z);
      @(posedge clk);
      #1;
      obs   = {ce_out, load, running, paused, done, alarm};
      exp_v = {m_ce, m_load, m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_DONE, m_alarm};
      $display("t=%0t btn=%b%b%b z=%b out(ce,ld,run,pau,dn,al)=%b exp=%b",
               $time, s, p, c, z, obs, exp_v);
      chk("outputs", 32'(obs), 32'(exp_v));
   endtask

   initial begin
      int ce_at[$];
      int n;
      reset = 1; start_btn = 1; pause_btn = 0; clear_btn = 0; digits_zero = 0;
      model_reset();
      // 1. reset with start held; no edge afterwards
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 32'({ce_out, load, running, paused, done, alarm}), 32'(0));
      @(negedge clk);
      reset = 0;
      repeat (3) step(1, 0, 0, 0);
      chk("no_start_on_held", 32'(running), 32'(0));

      // 2. start and three ticks
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("entry_load", 32'({load, running}), 32'(2'b11));
      for (int i = 1; i <= 12; i++) begin
         step(1, 0, 0, 0);
         if (ce_out) ce_at.push_back(i);
      end
      chk("ce_count", 32'(ce_at.size()), 32'(3));
      if (ce_at.size() == 3) begin
         chk("ce_first", 32'(ce_at[0]), 32'(4));
         chk("ce_third", 32'(ce_at[2]), 32'(12));
      end

      // 3. zero flag two cycles after third ce, then DONE alarm sequence
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("done_entry", 32'({done, ce_out}), 32'(2'b10));
      repeat (9) step(0, 0, 0, 1);
      chk("done_exit", 32'({done, alarm}), 32'(0));

      // 4. pause at prescaler 2, resume ten cycles later
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("paused", 32'(paused), 32'(1));
      repeat (3) step(0, 1, 0, 0);
      repeat (6) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("resumed", 32'(running), 32'(1));
      step(0, 0, 0, 0);
      chk("resume_ce", 32'(ce_out), 32'(1));

      // 5. clear coinciding with a tick
      n = 0;
      while (!(m_mode == M_RUN && m_phase == TD - 1) && n < 20) begin
         step(0, 0, 0, 0);
         n++;
      end
      chk("tick_reached", 32'(n < 20), 32'(1));
      step(0, 0, 1, 0);
      chk("clear_tick", 32'({ce_out, load, running}), 32'(3'b010));
      step(0, 0, 1, 0);
      chk("clear_load_once", 32'(load), 32'(0));

      // 6. start with a zero preset
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("zero_preset_done", 32'({done, ce_out}), 32'(2'b10));
      repeat (16) step(0, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         logic s, p, c, z;
         s = ($urandom_range(0, 9) == 0);
         p = ($urandom_range(0, 11) == 0);
         c = ($urandom_range(0, 15) == 0);
         z = ($urandom_range(0, 5) == 0) ? ~digits_zero : digits_zero;
         step(s, p, c, z);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
